// File: rtl/fluxo_dados_jogo_param.sv
// Parametrised datapath for the memory-sequence game.
// Counters, play register, edge detector, sequence memory and comparators.
module fluxo_dados_jogo_param #(
    parameter int NB        = 4,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int TIMEOUT   = 5000,
    parameter int TW        = 13,
    parameter int MAX_ERROS = 3,
    localparam int EW       = $clog2(MAX_ERROS + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          zeraE,
    input  logic          contaE,
    input  logic          zeraCR,
    input  logic          contaCR,
    input  logic          contaT,
    input  logic          limpaRC,
    input  logic          registraRC,
    input  logic          zeraLeds,
    input  logic          registraLeds,
    input  logic          led_selector,
    input  logic          escreveM,
    input  logic          zeraErro,
    input  logic          contaErro,
    input  logic [NB-1:0] botoes,
    output logic          jogada_correta,
    output logic          enderecoIgualRodada,
    output logic          fimE,
    output logic          fimR,
    output logic          jogada_feita,
    output logic          jogada_invalida,
    output logic          timeout,
    output logic          meio,
    output logic          fim_vidas,
    output logic [NB-1:0] leds,
    output logic [AW-1:0] db_endereco,
    output logic [AW-1:0] db_rodada,
    output logic [NB-1:0] db_jogada,
    output logic [NB-1:0] db_memoria,
    output logic [EW-1:0] db_erros,
    output logic          db_tem_jogada
);

    logic [AW-1:0] end_q, end_d;
    logic [AW-1:0] rod_q, rod_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [NB-1:0] jog_q, jog_d;
    logic [EW-1:0] err_q, err_d;
    logic          sel_q, sel_d;
    logic          prev_q, prev_d;
    logic [NB-1:0] mem_q [DEPTH];
    logic [AW-1:0] addr;
    logic          tem;

    assign tem  = |botoes;
    assign addr = sel_q ? rod_q : end_q;

    always_comb begin
        end_d  = end_q;
        rod_d  = rod_q;
        tmo_d  = tmo_q;
        jog_d  = jog_q;
        err_d  = err_q;
        sel_d  = sel_q;
        prev_d = tem;

        if (zeraE) end_d = '0;
        else if (contaE) end_d = (end_q == AW'(DEPTH - 1)) ? '0 : end_q + 1'b1;

        if (zeraCR) rod_d = '0;
        else if (contaCR) rod_d = (rod_q == AW'(DEPTH - 1)) ? '0 : rod_q + 1'b1;

        // Any restart of the play window beats the enable.
        if (zeraE | zeraCR | limpaRC | contaE) tmo_d = '0;
        else if (contaT) tmo_d = (tmo_q == TW'(TIMEOUT - 1)) ? '0 : tmo_q + 1'b1;

        if (limpaRC) jog_d = '0;
        else if (registraRC) jog_d = botoes;

        if (zeraErro) err_d = '0;
        else if (contaErro && err_q != EW'(MAX_ERROS)) err_d = err_q + 1'b1;

        if (zeraLeds) sel_d = 1'b0;
        else if (registraLeds) sel_d = led_selector;

        if (zeraCR) prev_d = 1'b0;

        if (reset) begin
            end_d  = '0;
            rod_d  = '0;
            tmo_d  = '0;
            jog_d  = '0;
            err_d  = '0;
            sel_d  = 1'b0;
            prev_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        end_q  <= end_d;
        rod_q  <= rod_d;
        tmo_q  <= tmo_d;
        jog_q  <= jog_d;
        err_q  <= err_d;
        sel_q  <= sel_d;
        prev_q <= prev_d;
    end

    // Memory is deliberately outside reset.
    always_ff @(posedge clock) begin
        if (escreveM) mem_q[addr] <= jog_q;
    end

    assign db_memoria          = mem_q[addr];
    assign db_endereco         = end_q;
    assign db_rodada           = rod_q;
    assign db_jogada           = jog_q;
    assign db_erros            = err_q;
    assign db_tem_jogada       = tem;
    assign jogada_feita        = tem & ~prev_q;
    assign jogada_invalida     = ($countones(jog_q) != 1);
    assign jogada_correta      = (db_memoria == jog_q) & ~jogada_invalida;
    assign enderecoIgualRodada = (end_q == rod_q);
    assign fimE                = (end_q == AW'(DEPTH - 1));
    assign fimR                = (rod_q == AW'(DEPTH - 1));
    assign timeout             = (tmo_q == TW'(TIMEOUT - 1));
    assign meio                = (tmo_q == TW'(TIMEOUT / 2));
    assign fim_vidas           = (err_q == EW'(MAX_ERROS));
    assign leds                = sel_q ? db_memoria : jog_q;

endmodule
